ntt_coeff_serializer: RTL and testbench

Parallel-to-serial unloader for the 16-point NTT/INTT datapath. Captures a full 16-coefficient vector from the parallel coefficient store in one cycle, then streams the coefficients out one per cycle over a valid/ready interface, in natural or bit-reversed order. It sits after the coefficient store and feeds the serial result path, such as the host readback or the next polynomial stage. It frees the store for the next load as soon as capture completes.

---
 rtl/ntt_pkg.sv | 26 ++
 rtl/ntt_coeff_serializer.sv | 154 +++++++++++++++
 tb/tb_ntt_coeff_serializer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT definitions: vector geometry, coefficient type, serializer states
// and the 4-bit index reversal used by loaders, twiddle addressing and unloaders.
package ntt_pkg;

  localparam int unsigned COEFF_WIDTH = 16;
  localparam int unsigned N           = 16;
  localparam int unsigned LOG_N       = 4;

  typedef logic [COEFF_WIDTH-1:0] coeff_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Mirror the index bits: {b3,b2,b1,b0} -> {b0,b1,b2,b3}.
  function automatic logic [LOG_N-1:0] bitrev4(input logic [LOG_N-1:0] idx);
    logic [LOG_N-1:0] r;
    r = '0;
    for (int i = 0; i < int'(LOG_N); i++) begin
      r[i] = idx[int'(LOG_N) - 1 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_coeff_serializer.sv
// Parallel-to-serial unloader: captures a 16-coefficient vector in one cycle and
// streams it out over valid/ready in natural or bit-reversed order.
module ntt_coeff_serializer
  import ntt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = COEFF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  bitrev,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic [DATA_WIDTH-1:0] din2,
  input  logic [DATA_WIDTH-1:0] din3,
  input  logic [DATA_WIDTH-1:0] din4,
  input  logic [DATA_WIDTH-1:0] din5,
  input  logic [DATA_WIDTH-1:0] din6,
  input  logic [DATA_WIDTH-1:0] din7,
  input  logic [DATA_WIDTH-1:0] din8,
  input  logic [DATA_WIDTH-1:0] din9,
  input  logic [DATA_WIDTH-1:0] din10,
  input  logic [DATA_WIDTH-1:0] din11,
  input  logic [DATA_WIDTH-1:0] din12,
  input  logic [DATA_WIDTH-1:0] din13,
  input  logic [DATA_WIDTH-1:0] din14,
  input  logic [DATA_WIDTH-1:0] din15,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [LOG_N-1:0]      m_index,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  state_t                  state;
  state_t                  state_nxt;
  logic [LOG_N-1:0]        cnt;
  logic [LOG_N-1:0]        cnt_nxt;
  logic                    mode_q;
  logic                    mode_nxt;
  logic                    done_q;
  logic                    done_nxt;
  logic                    capture;
  logic                    streaming;
  logic [LOG_N-1:0]        rd_idx;
  logic [DATA_WIDTH-1:0]   din_vec   [N];
  logic [DATA_WIDTH-1:0]   coeff_buf [N];

  // Gather the parallel ports into an indexable vector.
  always_comb begin
    din_vec[0]  = din0;
    din_vec[1]  = din1;
    din_vec[2]  = din2;
    din_vec[3]  = din3;
    din_vec[4]  = din4;
    din_vec[5]  = din5;
    din_vec[6]  = din6;
    din_vec[7]  = din7;
    din_vec[8]  = din8;
    din_vec[9]  = din9;
    din_vec[10] = din10;
    din_vec[11] = din11;
    din_vec[12] = din12;
    din_vec[13] = din13;
    din_vec[14] = din14;
    din_vec[15] = din15;
  end

  // Next-state logic; in STREAM m_valid is always high, so m_ready alone is the handshake.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mode_nxt  = mode_q;
    done_nxt  = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          mode_nxt  = bitrev;
          cnt_nxt   = 4'd0;
          state_nxt = STREAM;
        end else begin
          state_nxt = IDLE;
        end
      end
      STREAM: begin
        if (m_ready) begin
          if (cnt == 4'd15) begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
            done_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end else begin
          cnt_nxt = cnt;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
        mode_nxt  = 1'b0;
      end
    endcase
  end

  // Control registers with synchronous reset; reset mid-stream drops the vector without done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      mode_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      mode_q <= mode_nxt;
      done_q <= done_nxt;
    end
  end

  // Coefficient buffer: written only on the capture edge and intentionally not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(N); i++) begin
      if (capture) begin
        coeff_buf[i] <= din_vec[i];
      end else begin
        coeff_buf[i] <= coeff_buf[i];
      end
    end
  end

  // Output decode from registered state only; m_ready never reaches m_valid.
  always_comb begin
    streaming = (state == STREAM);
    rd_idx    = mode_q ? bitrev4(cnt) : cnt;
    m_valid   = streaming;
    busy      = streaming;
    done      = done_q;
    if (streaming) begin
      m_index = rd_idx;
      m_data  = coeff_buf[rd_idx];
      m_last  = (cnt == 4'd15);
    end else begin
      m_index = 4'd0;
      m_data  = '0;
      m_last  = 1'b0;
    end
  end

endmodule

// File: tb/tb_ntt_coeff_serializer.sv
// Self-checking bench for ntt_coeff_serializer: table-driven order checks,
// directed multi-cycle corner cases and a randomized run against a queue model.
module tb_ntt_coeff_serializer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        bitrev;
  logic [15:0] din [16];
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic [3:0]  m_index;
  logic        m_last;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of beats still owed downstream.
  logic [15:0] q_data [$];
  logic [3:0]  q_idx  [$];
  logic        done_exp = 1'b0;
  int          accepted = 0;

  typedef struct {
    logic        mode;
    logic [3:0]  exp_index;
    logic [15:0] exp_data;
    logic        exp_last;
  } vec_t;

  vec_t vecs [32];

  ntt_coeff_serializer dut (
    .clk(clk), .rst(rst), .start(start), .bitrev(bitrev),
    .din0(din[0]),   .din1(din[1]),   .din2(din[2]),   .din3(din[3]),
    .din4(din[4]),   .din5(din[5]),   .din6(din[6]),   .din7(din[7]),
    .din8(din[8]),   .din9(din[9]),   .din10(din[10]), .din11(din[11]),
    .din12(din[12]), .din13(din[13]), .din14(din[14]), .din15(din[15]),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
    .m_last(m_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] rev_model(input int i);
    int r;
    r = ((i % 2) * 8) + (((i / 2) % 2) * 4) + (((i / 4) % 2) * 2) + ((i / 8) % 2);
    return 4'(r);
  endfunction

  // Advance the model for the coming edge using the currently driven inputs.
  task automatic model_step();
    if (rst) begin
      q_data.delete();
      q_idx.delete();
      done_exp = 1'b0;
    end else if (q_data.size() > 0) begin
      done_exp = 1'b0;
      if (m_ready) begin
        void'(q_data.pop_front());
        void'(q_idx.pop_front());
        accepted++;
        if (q_data.size() == 0) done_exp = 1'b1;
      end
    end else begin
      done_exp = 1'b0;
      if (start) begin
        for (int i = 0; i < 16; i++) begin
          logic [3:0] k;
          k = bitrev ? rev_model(i) : 4'(i);
          q_idx.push_back(k);
          q_data.push_back(din[k]);
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic exp_valid;
    exp_valid = (q_data.size() > 0);
    chk("m_valid", 32'(m_valid), 32'(exp_valid));
    chk("busy", 32'(busy), 32'(exp_valid));
    chk("done", 32'(done), 32'(done_exp));
    if (exp_valid) begin
      chk("m_data", 32'(m_data), 32'(q_data[0]));
      chk("m_index", 32'(m_index), 32'(q_idx[0]));
      chk("m_last", 32'(m_last), 32'(q_data.size() == 1));
    end else begin
      chk("idle_data", 32'(m_data), 32'd0);
      chk("idle_index", 32'(m_index), 32'd0);
      chk("idle_last", 32'(m_last), 32'd0);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic load_din(input logic [15:0] base);
    for (int i = 0; i < 16; i++) din[i] = base + 16'(i);
  endtask

  task automatic wait_done(input string name, input int bound);
    int n;
    n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int brl [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    rst = 1'b1; start = 1'b0; bitrev = 1'b0; m_ready = 1'b1;
    load_din(16'h0000);

    for (int i = 0; i < 16; i++) begin
      vecs[i]      = '{1'b0, 4'(i), 16'h1000 + 16'(i), (i == 15)};
      vecs[16 + i] = '{1'b1, 4'(brl[i]), 16'h1000 + 16'(brl[i]), (i == 15)};
    end

    // Reset state
    tick(); tick();
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // Table-driven natural and bit-reversed streams with m_ready held high
    load_din(16'h1000);
    for (int i = 0; i < 32; i++) begin
      if (i % 16 == 0) begin
        start = 1'b1; bitrev = vecs[i].mode; m_ready = 1'b1;
        tick();
        start = 1'b0;
      end
      chk("tbl_valid", 32'(m_valid), 32'd1);
      chk("tbl_index", 32'(m_index), 32'(vecs[i].exp_index));
      chk("tbl_data", 32'(m_data), 32'(vecs[i].exp_data));
      chk("tbl_last", 32'(m_last), 32'(vecs[i].exp_last));
      tick();
      if (i % 16 == 15) begin
        chk("tbl_done", 32'(done), 32'd1);
        chk("tbl_done_valid", 32'(m_valid), 32'd0);
        tick();
        chk("tbl_done_pulse", 32'(done), 32'd0);
      end
    end

    // Backpressure with pseudo-random m_ready
    accepted = 0;
    start = 1'b1; bitrev = 1'b0;
    tick();
    start = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      m_ready = ($urandom_range(0, 99) < 45);
      tick();
      if (done) chk("bp_accepted", 32'(accepted), 32'd16);
    end
    if (!done) chk("bp_timeout", 32'd0, 32'd1);
    m_ready = 1'b1;
    tick();

    // Capture isolation: din overwritten and a second start mid-stream
    load_din(16'h1000);
    start = 1'b1; bitrev = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) din[i] = 16'hFFFF;
    for (int b = 0; b < 5; b++) tick();
    start = 1'b1;
    chk("iso_beat5", 32'(m_data), 32'h1005);
    tick();
    start = 1'b0;
    wait_done("iso", 40);
    chk("iso_idle_after", 32'(m_valid), 32'd0);

    // Back-to-back: start during the done cycle
    load_din(16'h2000);
    start = 1'b1; bitrev = 1'b0;
    tick();
    start = 1'b0;
    chk("b2b_first", 32'(m_data), 32'h2000);
    chk("b2b_first_valid", 32'(m_valid), 32'd1);
    tick();
    chk("b2b_second", 32'(m_data), 32'h2001);
    wait_done("b2b", 40);
    tick();

    // Reset mid-stream at beat 7
    load_din(16'h3000);
    start = 1'b1; bitrev = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 7; b++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid", 32'(m_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    tick();
    chk("mrst_no_done", 32'(done), 32'd0);
    start = 1'b1; bitrev = 1'b0;
    tick();
    start = 1'b0;
    chk("mrst_restart_index", 32'(m_index), 32'd0);
    chk("mrst_restart_data", 32'(m_data), 32'h3000);
    wait_done("mrst", 40);
    tick();

    // Randomized traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 299) == 0);
      start   = ($urandom_range(0, 3) == 0);
      bitrev  = 1'($urandom_range(0, 1));
      m_ready = ($urandom_range(0, 99) < 70);
      for (int i = 0; i < 16; i++) din[i] = 16'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
